// File: rtl/penc_arb_pkg.sv
// Shared types and constants for the penc_arb priority arbiter.
package penc_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int N_MIN = 2;
  localparam int N_MAX = 32;

endpackage

// File: rtl/penc_arb_if.sv
// Request/grant bundle between request sources (master) and the arbiter (slave).
interface penc_arb_if #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) ();

  logic [N-1:0] req;
  logic         ack;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
  logic         valid;

  modport master (
    output req, ack,
    input  gnt_idx, gnt_onehot, valid
  );

  modport slave (
    input  req, ack,
    output gnt_idx, gnt_onehot, valid
  );

endinterface

// File: rtl/penc_arb_penc_n.sv
// Combinational N-bit highest-set-bit encoder with an any-set flag.
module penc_n #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Ascending scan so the highest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = W'(i);
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/penc_arb.sv
// N-input arbiter: fixed priority (highest index) or round-robin, registered grant held until ack/withdrawal.
module penc_arb
  import penc_arb_pkg::*;
#(
  parameter int N  = 8,
  parameter int W  = $clog2(N),
  parameter int RR = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  penc_arb_if.slave   bus
);

  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $error("penc_arb: N out of range");
  end

  arb_state_e   state_q;
  logic [W-1:0] gnt_idx_q;
  logic [N-1:0] gnt_oh_q;
  logic [W-1:0] last_q;

  logic           release_w;
  logic [W-1:0]   rot_base;
  logic [N-1:0]   cand;
  logic [2*N-1:0] cand_dbl;
  logic [N-1:0]   rotated;
  logic [W-1:0]   enc_idx;
  logic           enc_any;
  logic [W:0]     idx_sum;
  logic [W-1:0]   gnt_idx_d;
  logic [N-1:0]   gnt_oh_d;

  assign release_w = (state_q == GRANT) && (bus.ack || !bus.req[gnt_idx_q]);

  // On release the outgoing grantee is masked and already counts as LAST for the search.
  assign rot_base = (RR != 0) ? (release_w ? gnt_idx_q : last_q) : '0;
  assign cand     = release_w ? (bus.req & ~gnt_oh_q) : bus.req;

  // Rotate so bit (rot_base-1) mod N lands at the top; the encoder then searches downward with wrap.
  assign cand_dbl = {cand, cand};
  assign rotated  = N'(cand_dbl >> rot_base);

  penc_n #(
    .N (N),
    .W (W)
  ) u_penc (
    .req_i (rotated),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  assign idx_sum   = {1'b0, enc_idx} + {1'b0, rot_base};
  assign gnt_idx_d = (idx_sum >= (W+1)'(N)) ? W'(idx_sum - (W+1)'(N)) : W'(idx_sum);
  assign gnt_oh_d  = {{(N-1){1'b0}}, 1'b1} << gnt_idx_d;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      gnt_oh_q  <= '0;
      last_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enc_any) begin
            state_q   <= GRANT;
            gnt_idx_q <= gnt_idx_d;
            gnt_oh_q  <= gnt_oh_d;
          end
        end
        GRANT: begin
          if (release_w) begin
            last_q <= gnt_idx_q;
            if (enc_any) begin
              gnt_idx_q <= gnt_idx_d;
              gnt_oh_q  <= gnt_oh_d;
            end else begin
              state_q   <= IDLE;
              gnt_idx_q <= '0;
              gnt_oh_q  <= '0;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          gnt_idx_q <= '0;
          gnt_oh_q  <= '0;
        end
      endcase
    end
  end

  assign bus.gnt_idx    = gnt_idx_q;
  assign bus.gnt_onehot = gnt_oh_q;
  assign bus.valid      = (state_q == GRANT);

endmodule
